// File: rtl/alu_dispatch.sv
// Instruction dispatcher for an external 8-bit ALU: latches an instruction,
// drives the ALU operands for one cycle, then writes the result back.
module alu_dispatch #(
    parameter bit R0_ZERO = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    output logic       instr_ready,
    input  logic [3:0] instr_op,
    input  logic [2:0] instr_rd,
    input  logic [2:0] instr_rs,
    input  logic [2:0] instr_rt,
    input  logic       instr_imm_en,
    input  logic [7:0] instr_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [3:0] alu_cont,
    input  logic [7:0] alu_out,
    input  logic       alu_zero,
    output logic       wb_valid,
    output logic [2:0] wb_rd,
    output logic [7:0] wb_data,
    output logic       zero_q,
    output logic       illegal_op
);

    // state | meaning
    // IDLE  | waiting for an instruction
    // EXEC  | operands on the ALU, result captured at end of cycle
    // WB    | result written to rf; a new instruction may be accepted
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [2:0]  rd_q, rs_q, rt_q;
    logic        imm_en_q;
    logic [7:0]  imm_q;
    logic [7:0]  result_q;
    logic        zf_q;
    logic [7:0]  rf_q [8];
    logic        accept;
    logic        op_legal;
    logic [7:0]  rs_val, rt_val;
    logic        rf_we;

    assign instr_ready = ((state_q == S_IDLE) || (state_q == S_WB)) && !reset;
    assign accept      = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = accept ? S_EXEC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (op_q)
            4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    // Reads see the value written at the edge that entered EXEC, so a
    // consumer accepted in a producer's WB needs no forwarding.
    always_comb begin
        rs_val = rf_q[rs_q];
        rt_val = rf_q[rt_q];
        if (R0_ZERO && (rs_q == 3'd0)) rs_val = 8'h00;
        if (R0_ZERO && (rt_q == 3'd0)) rt_val = 8'h00;
    end

    assign rf_we = (state_q == S_WB) && op_legal && !(R0_ZERO && (rd_q == 3'd0));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q     <= 4'h0;
            rd_q     <= 3'd0;
            rs_q     <= 3'd0;
            rt_q     <= 3'd0;
            imm_en_q <= 1'b0;
            imm_q    <= 8'h00;
        end else if (accept) begin
            op_q     <= instr_op;
            rd_q     <= instr_rd;
            rs_q     <= instr_rs;
            rt_q     <= instr_rt;
            imm_en_q <= instr_imm_en;
            imm_q    <= instr_imm;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= 8'h00;
            zf_q     <= 1'b0;
            zero_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 8'h00;
            end
        end else begin
            if (state_q == S_EXEC) begin
                result_q <= alu_out;
                zf_q     <= alu_zero;
            end
            if ((state_q == S_WB) && op_legal) begin
                zero_q <= zf_q;
            end
            if (rf_we) begin
                rf_q[rd_q] <= result_q;
            end
        end
    end

    always_comb begin
        alu_a      = 8'h00;
        alu_b      = 8'h00;
        alu_cont   = 4'h0;
        wb_valid   = 1'b0;
        wb_rd      = 3'd0;
        wb_data    = 8'h00;
        illegal_op = 1'b0;
        case (state_q)
            S_EXEC: begin
                alu_a    = rs_val;
                alu_b    = imm_en_q ? imm_q : rt_val;
                alu_cont = op_legal ? op_q : 4'h0;
            end
            S_WB: begin
                if (op_legal) begin
                    wb_valid = 1'b1;
                    wb_rd    = rd_q;
                    wb_data  = result_q;
                end else begin
                    illegal_op = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_dispatch.sv
// Bench for alu_dispatch: ALU model on the operand outputs, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_alu_dispatch;

    localparam bit R0 = 1'b1;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [3:0] instr_op = 4'h0;
    logic [2:0] instr_rd = 3'd0;
    logic [2:0] instr_rs = 3'd0;
    logic [2:0] instr_rt = 3'd0;
    logic       instr_imm_en = 1'b0;
    logic [7:0] instr_imm = 8'h00;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [3:0] alu_cont;
    logic       alu_zero;
    logic       wb_valid;
    logic [2:0] wb_rd;
    logic [7:0] wb_data;
    logic       zero_q;
    logic       illegal_op;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_dispatch #(.R0_ZERO(R0)) dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
        .instr_rt(instr_rt), .instr_imm_en(instr_imm_en), .instr_imm(instr_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .zero_q(zero_q), .illegal_op(illegal_op)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h5:    return a | ~b;
            4'h6:    return a - b;
            4'h7:    return ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_out  = alu_f(alu_cont, alu_a, alu_b);
    assign alu_zero = (alu_out == 8'h00);

    function automatic bit is_legal(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'h5, 4'h6, 4'h7};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: one instruction in execute, one in writeback.
    logic [7:0] m_rf [8];
    logic       m_zero = 1'b0;
    logic       m_ex_v = 1'b0, m_ex_legal = 1'b0;
    logic [2:0] m_ex_rd = 3'd0;
    logic [7:0] m_ex_a = 8'h00, m_ex_b = 8'h00, m_ex_res = 8'h00;
    logic [3:0] m_ex_c = 4'h0;
    logic       m_wb_v = 1'b0, m_wb_legal = 1'b0, m_wb_z = 1'b0;
    logic [2:0] m_wb_rd = 3'd0;
    logic [7:0] m_wb_res = 8'h00;

    function automatic logic [7:0] m_read(input logic [2:0] idx);
        if (R0 && idx == 3'd0) return 8'h00;
        return m_rf[idx];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
            m_zero = 1'b0;
            m_ex_v = 1'b0;
            m_wb_v = 1'b0;
        end else begin
            bit acc;
            acc = instr_valid && !m_ex_v;
            if (m_wb_v && m_wb_legal) begin
                if (!(R0 && m_wb_rd == 3'd0)) m_rf[m_wb_rd] = m_wb_res;
                m_zero = m_wb_z;
            end
            m_wb_v     = m_ex_v;
            m_wb_legal = m_ex_legal;
            m_wb_rd    = m_ex_rd;
            m_wb_res   = m_ex_res;
            m_wb_z     = (m_ex_res == 8'h00);
            m_ex_v     = acc;
            if (acc) begin
                m_ex_legal = is_legal(instr_op);
                m_ex_rd    = instr_rd;
                m_ex_a     = m_read(instr_rs);
                m_ex_b     = instr_imm_en ? instr_imm : m_read(instr_rt);
                m_ex_c     = m_ex_legal ? instr_op : 4'h0;
                m_ex_res   = alu_f(m_ex_c, m_ex_a, m_ex_b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", 32'(instr_ready), 32'(!reset && !m_ex_v));
            chk("m_alu_a", 32'(alu_a), 32'(m_ex_v ? m_ex_a : 8'h00));
            chk("m_alu_b", 32'(alu_b), 32'(m_ex_v ? m_ex_b : 8'h00));
            chk("m_alu_cont", 32'(alu_cont), 32'(m_ex_v ? m_ex_c : 4'h0));
            chk("m_wb_valid", 32'(wb_valid), 32'(m_wb_v && m_wb_legal));
            chk("m_illegal", 32'(illegal_op), 32'(m_wb_v && !m_wb_legal));
            if (m_wb_v && m_wb_legal) begin
                chk("m_wb_rd", 32'(wb_rd), 32'(m_wb_rd));
                chk("m_wb_data", 32'(wb_data), 32'(m_wb_res));
            end else if (!m_wb_v) begin
                chk("m_wb_rd_idle", 32'(wb_rd), 32'h0);
                chk("m_wb_data_idle", 32'(wb_data), 32'h0);
            end
            chk("m_zero_q", 32'(zero_q), 32'(m_zero));
        end
    end

    // Offers an instruction and returns #1 after the edge that accepted it.
    task automatic issue(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs,
                         input logic [2:0] rt, input logic ie, input logic [7:0] imm);
        bit done;
        bit r;
        done = 1'b0;
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_rs = rs; instr_rt = rt;
        instr_imm_en = ie; instr_imm = imm;
        for (int i = 0; i < 10 && !done; i++) begin
            r = instr_ready;
            @(posedge clk); #1;
            if (r) done = 1'b1;
        end
        instr_valid = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout op=%0h: got no accept, expected accept within 10 cycles", op);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, expected finish before 100000");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
        @(posedge clk);
        @(negedge clk); #1 reset = 1'b0;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'h1);
        chk("rst_wb_valid", 32'(wb_valid), 32'h0);
        chk("rst_zero_q", 32'(zero_q), 32'h0);
        chk("rst_alu_a", 32'(alu_a), 32'h0);
        chk("rst_illegal", 32'(illegal_op), 32'h0);

        // r1=0F, r2=33, r3=r1+r2
        issue(4'h1, 3'd1, 3'd0, 3'd0, 1'b1, 8'h0F);
        issue(4'h1, 3'd2, 3'd0, 3'd0, 1'b1, 8'h33);
        issue(4'h2, 3'd3, 3'd1, 3'd2, 1'b0, 8'h00);
        chk("add_alu_a", 32'(alu_a), 32'h0F);
        chk("add_alu_b", 32'(alu_b), 32'h33);
        chk("add_alu_cont", 32'(alu_cont), 32'h2);
        next_cycle();
        chk("add_wb_valid", 32'(wb_valid), 32'h1);
        chk("add_wb_rd", 32'(wb_rd), 32'h3);
        chk("add_wb_data", 32'(wb_data), 32'h42);
        next_cycle();
        chk("add_zero_q", 32'(zero_q), 32'h0);

        // back-to-back dependency through r4
        issue(4'h1, 3'd4, 3'd0, 3'd0, 1'b1, 8'h05);
        issue(4'h6, 3'd6, 3'd4, 3'd0, 1'b1, 8'h05);
        chk("raw_alu_a", 32'(alu_a), 32'h05);
        chk("raw_alu_cont", 32'(alu_cont), 32'h6);
        next_cycle();
        chk("raw_wb_valid", 32'(wb_valid), 32'h1);
        chk("raw_wb_data", 32'(wb_data), 32'h00);
        next_cycle();
        chk("raw_zero_q", 32'(zero_q), 32'h1);

        // write to r0 is discarded
        issue(4'h1, 3'd0, 3'd0, 3'd0, 1'b1, 8'hAA);
        next_cycle();
        chk("r0_wb_valid", 32'(wb_valid), 32'h1);
        chk("r0_wb_data", 32'(wb_data), 32'hAA);
        next_cycle();
        issue(4'h1, 3'd7, 3'd0, 3'd0, 1'b1, 8'h80);
        chk("r0_read", 32'(alu_a), 32'h00);
        next_cycle();
        next_cycle();
        chk("r0_zero_q", 32'(zero_q), 32'h0);

        // illegal ops: zero flag would be 1, must not land in zero_q
        issue(4'h3, 3'd1, 3'd0, 3'd0, 1'b0, 8'h00);
        chk("ill3_alu_cont", 32'(alu_cont), 32'h0);
        next_cycle();
        chk("ill3_illegal", 32'(illegal_op), 32'h1);
        chk("ill3_wb_valid", 32'(wb_valid), 32'h0);
        issue(4'hA, 3'd2, 3'd0, 3'd0, 1'b0, 8'h00);
        next_cycle();
        chk("illA_illegal", 32'(illegal_op), 32'h1);
        chk("illA_wb_valid", 32'(wb_valid), 32'h0);
        next_cycle();
        chk("ill_zero_q", 32'(zero_q), 32'h0);
        issue(4'hF, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00);
        issue(4'h1, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00);
        chk("ill_r1_kept", 32'(alu_a), 32'h0F);
        chk("ill_r2_kept", 32'(alu_b), 32'h33);

        // remaining ALU functions, rd equal to sources
        issue(4'h0, 3'd7, 3'd1, 3'd2, 1'b0, 8'h00);
        issue(4'h5, 3'd6, 3'd1, 3'd2, 1'b0, 8'h00);
        issue(4'h7, 3'd5, 3'd2, 3'd1, 1'b0, 8'h00);
        issue(4'h2, 3'd1, 3'd1, 3'd1, 1'b0, 8'h00);
        issue(4'h1, 3'd7, 3'd1, 3'd0, 1'b1, 8'h00);
        chk("rdrs_alu_a", 32'(alu_a), 32'h1E);
        next_cycle();
        next_cycle();

        // reset during EXEC of a write to r5
        issue(4'h1, 3'd5, 3'd0, 3'd0, 1'b1, 8'h5A);
        #2 reset = 1'b1;
        #1;
        chk("rx_ready", 32'(instr_ready), 32'h0);
        chk("rx_alu_b", 32'(alu_b), 32'h00);
        next_cycle();
        chk("rx_wb_valid", 32'(wb_valid), 32'h0);
        @(negedge clk); #1 reset = 1'b0;
        #1;
        chk("rx_ready_rel", 32'(instr_ready), 32'h1);
        issue(4'h1, 3'd7, 3'd5, 3'd0, 1'b1, 8'h00);
        chk("rx_r5", 32'(alu_a), 32'h00);
        next_cycle();
        next_cycle();
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
